// File: rtl/decode_hazard_scoreboard_if.sv
// Decode/writeback/flush bundle between the decode stage, register file and
// the hazard scoreboard. The master drives the requests; the scoreboard answers.
interface decode_hazard_scoreboard_if #(
   parameter int NUM_REGS = 32,
   parameter int IDX_W    = 5,
   parameter int CNT_W    = 16
);
   logic                dec_valid;
   logic [IDX_W-1:0]    dec_rs;
   logic [IDX_W-1:0]    dec_rt;
   logic                dec_uses_rs;
   logic                dec_uses_rt;
   logic                dec_writes;
   logic [IDX_W-1:0]    dec_dest;
   logic                wb_valid;
   logic [IDX_W-1:0]    wb_reg;
   logic                flush;
   logic                issue;
   logic                stall;
   logic [NUM_REGS-1:0] busy_mask;
   logic [CNT_W-1:0]    stall_count;
   logic                err_spurious_wb;

   modport master (
      output dec_valid, dec_rs, dec_rt, dec_uses_rs, dec_uses_rt, dec_writes,
             dec_dest, wb_valid, wb_reg, flush,
      input  issue, stall, busy_mask, stall_count, err_spurious_wb
   );

   modport slave (
      input  dec_valid, dec_rs, dec_rt, dec_uses_rs, dec_uses_rt, dec_writes,
             dec_dest, wb_valid, wb_reg, flush,
      output issue, stall, busy_mask, stall_count, err_spurious_wb
   );
endinterface

// File: rtl/decode_hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight register writes, stalls
// decode on RAW/WAW conflicts and drains all pending writes after a flush.
module decode_hazard_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int IDX_W    = 5,
   parameter int CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   decode_hazard_scoreboard_if.slave bus
);

   typedef enum logic [1:0] {RUN, STALL, DRAIN} state_e;

   state_e              state_q, state_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [NUM_REGS-1:0] wb_hit, set_hit, eff;
   logic [CNT_W-1:0]    cnt_q;
   logic                err_q;
   logic                hazard, issue_c, stall_c;

   // Per-register tracking; register 0 is hardwired zero and never tracked.
   for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      if (r == 0) begin : g_zero
         assign wb_hit[r]  = 1'b0;
         assign set_hit[r] = 1'b0;
         assign busy_d[r]  = 1'b0;
      end else begin : g_trk
         assign wb_hit[r]  = bus.wb_valid && (bus.wb_reg == IDX_W'(r));
         assign set_hit[r] = issue_c && bus.dec_writes && (bus.dec_dest == IDX_W'(r));
         // A new writer supersedes a same-cycle writeback of the old one.
         assign busy_d[r]  = set_hit[r] | (busy_q[r] & ~wb_hit[r]);
      end
   end

   // Write-through register file: a same-cycle writeback already resolves.
   assign eff = busy_q & ~wb_hit;

   always_comb begin
      hazard = 1'b0;
      if (bus.dec_uses_rs && eff[bus.dec_rs] && (bus.dec_rs != '0))
         hazard = 1'b1;
      if (bus.dec_uses_rt && eff[bus.dec_rt] && (bus.dec_rt != '0))
         hazard = 1'b1;
      if (bus.dec_writes && eff[bus.dec_dest] && (bus.dec_dest != '0))
         hazard = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      issue_c = 1'b0;
      stall_c = 1'b0;
      unique case (state_q)
         RUN: begin
            if (bus.dec_valid && !hazard) begin
               issue_c = 1'b1;
            end else if (bus.dec_valid) begin
               stall_c = 1'b1;
               state_d = STALL;
            end
         end
         STALL: begin
            if (!bus.dec_valid) begin
               state_d = RUN;
            end else if (hazard) begin
               stall_c = 1'b1;
            end else begin
               issue_c = 1'b1;
               state_d = RUN;
            end
         end
         DRAIN: begin
            stall_c = bus.dec_valid;
            if (eff == '0)
               state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      // Flush discards the decoded instruction rather than holding it.
      if (bus.flush) begin
         state_d = DRAIN;
         issue_c = 1'b0;
         if (state_q != DRAIN)
            stall_c = 1'b0;
      end
      if (!rst_n) begin
         issue_c = 1'b0;
         stall_c = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         busy_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         if (stall_c && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
         if (|(wb_hit & ~busy_q))
            err_q <= 1'b1;
      end
   end

   assign bus.issue           = issue_c;
   assign bus.stall           = stall_c;
   assign bus.busy_mask       = busy_q;
   assign bus.stall_count     = cnt_q;
   assign bus.err_spurious_wb = err_q;

endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// Self-checking bench for decode_hazard_scoreboard: table of cycle vectors
// through a scoreboard queue, then hand sequences for error, saturation, reset.
module tb_decode_hazard_scoreboard;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   decode_hazard_scoreboard_if #(.NUM_REGS(32), .IDX_W(5), .CNT_W(16)) bus ();

   decode_hazard_scoreboard #(.NUM_REGS(32), .IDX_W(5), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic        v;
      logic [4:0]  rs;
      logic        urs;
      logic [4:0]  rt;
      logic        urt;
      logic        wr;
      logic [4:0]  dst;
      logic        wbv;
      logic [4:0]  wbr;
      logic        fl;
      logic        e_iss;
      logic        e_stl;
      logic [31:0] e_busy;
   } vec_t;

   int   total = 0;
   int   bad   = 0;
   vec_t tbl[21];
   vec_t exp_q[$];

   function automatic vec_t mk(input logic v, input int rs, input logic urs,
                               input int rt, input logic urt, input logic wr,
                               input int dst, input logic wbv, input int wbr,
                               input logic fl, input logic ei, input logic es,
                               input logic [31:0] eb);
      vec_t t;
      t.v = v; t.rs = 5'(rs); t.urs = urs; t.rt = 5'(rt); t.urt = urt;
      t.wr = wr; t.dst = 5'(dst); t.wbv = wbv; t.wbr = 5'(wbr); t.fl = fl;
      t.e_iss = ei; t.e_stl = es; t.e_busy = eb;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic put(input vec_t t);
      bus.dec_valid   = t.v;
      bus.dec_rs      = t.rs;
      bus.dec_uses_rs = t.urs;
      bus.dec_rt      = t.rt;
      bus.dec_uses_rt = t.urt;
      bus.dec_writes  = t.wr;
      bus.dec_dest    = t.dst;
      bus.wb_valid    = t.wbv;
      bus.wb_reg      = t.wbr;
      bus.flush       = t.fl;
   endtask

   // Drive one cycle; comb outputs checked mid-cycle, busy_mask after the edge.
   task automatic step(input vec_t t, input int idx);
      vec_t e;
      put(t);
      exp_q.push_back(t);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("issue[%0d]", idx), 32'(bus.issue), 32'(e.e_iss));
      chk($sformatf("stall[%0d]", idx), 32'(bus.stall), 32'(e.e_stl));
      @(posedge clk); #1;
      chk($sformatf("busy[%0d]", idx), bus.busy_mask, e.e_busy);
   endtask

   initial begin
      //               v rs urs rt urt wr dst wbv wbr fl  iss stl busy
      tbl[0]  = mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 32'h8);
      tbl[1]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8);
      tbl[2]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8);
      tbl[3]  = mk(1, 3, 1, 0, 0, 0, 0, 1, 3, 0, 1, 0, 32'h0);
      tbl[4]  = mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h0);
      tbl[5]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 0, 32'h20);
      tbl[6]  = mk(1, 0, 1, 0, 0, 1, 7, 0, 0, 0, 1, 0, 32'hA0);
      tbl[7]  = mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 32'hA0);
      tbl[8]  = mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 1, 0, 0, 32'hA0);
      tbl[9]  = mk(1, 0, 0, 0, 0, 1, 9, 1, 5, 0, 0, 1, 32'h80);
      tbl[10] = mk(1, 0, 0, 0, 0, 1, 9, 1, 7, 0, 0, 1, 32'h0);
      tbl[11] = mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 1, 0, 32'h10);
      tbl[12] = mk(1, 0, 0, 0, 0, 1, 4, 1, 4, 0, 1, 0, 32'h10);
      tbl[13] = mk(1, 4, 1, 0, 0, 1, 4, 0, 0, 0, 0, 1, 32'h10);
      tbl[14] = mk(0, 4, 1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 32'h10);
      tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 32'h0);
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0);
      tbl[17] = mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 32'h0);
      tbl[18] = mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 32'h4);
      tbl[19] = mk(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1, 32'h4);
      tbl[20] = mk(1, 0, 0, 2, 1, 0, 0, 1, 2, 0, 1, 0, 32'h0);

      // Reset with a live request: outputs stay quiet.
      rst_n = 1'b0;
      put(mk(1, 0, 0, 0, 0, 1, 3, 1, 9, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1;
      chk("rst_issue", 32'(bus.issue), 0);
      chk("rst_stall", 32'(bus.stall), 0);
      chk("rst_busy", bus.busy_mask, 0);
      chk("rst_count", 32'(bus.stall_count), 0);
      chk("rst_err", 32'(bus.err_spurious_wb), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 21; i++) step(tbl[i], i);
      chk("err_after_table", 32'(bus.err_spurious_wb), 0);
      chk("count_after_table", 32'(bus.stall_count), 7);

      // Writeback to r0 is ignored; to a non-pending register it is sticky.
      step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0), 100);
      chk("err_wb_r0", 32'(bus.err_spurious_wb), 0);
      step(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 32'h0), 101);
      chk("err_wb_r9", 32'(bus.err_spurious_wb), 1);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0), 102);
      chk("err_sticky", 32'(bus.err_spurious_wb), 1);

      // Long stall on r1 to saturate the counter.
      step(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 32'h2), 103);
      put(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (70000) @(posedge clk);
      #1;
      chk("count_sat", 32'(bus.stall_count), 32'hFFFF);
      chk("sat_still_stall", 32'(bus.stall), 1);
      @(posedge clk); #1;
      chk("count_no_wrap", 32'(bus.stall_count), 32'hFFFF);

      // Flush with r1 pending, then reset asynchronously mid-drain.
      step(mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 1, 0, 0, 32'h2), 104);
      step(mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 1, 32'h2), 105);
      @(negedge clk);
      chk("drain_stall", 32'(bus.stall), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_issue", 32'(bus.issue), 0);
      chk("midrst_stall", 32'(bus.stall), 0);
      chk("midrst_busy", bus.busy_mask, 0);
      chk("midrst_count", 32'(bus.stall_count), 0);
      chk("midrst_err", 32'(bus.err_spurious_wb), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      // Back in RUN with nothing pending: the held request issues at once.
      step(mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 1, 0, 32'h40), 106);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_hazard_scoreboard.md
Name: decode_hazard_scoreboard

Overview:
- Pipeline controller for the decode stage and register file.
- Tracks which architectural registers have a write in flight. Stalls decode when a source or destination register of the instruction currently in decode is still pending.
- Releases the stall when the matching register-file writeback occurs.
- Sequences a pipeline flush by draining all pending writes before decode resumes.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero and never tracked.
- IDX_W, 5, register index width; must equal clog2(NUM_REGS).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock shared with the decode stage and register file.
- rst_n  in  1  asynchronous, active-low reset.
- dec_valid  in  1  a decoded instruction is present and requests issue.
- dec_rs  in  IDX_W  first source register index.
- dec_rt  in  IDX_W  second source register index.
- dec_uses_rs  in  1  instruction reads rs.
- dec_uses_rt  in  1  instruction reads rt.
- dec_writes  in  1  instruction writes a destination register.
- dec_dest  in  IDX_W  destination register (rd or rt, already selected by decode).
- wb_valid  in  1  register-file write this cycle (same strobe as RegWrite).
- wb_reg  in  IDX_W  register written this cycle.
- flush  in  1  single-cycle pipeline flush request.
- issue  out  1  decode instruction accepted this cycle.
- stall  out  1  decode must hold its instruction this cycle.
- busy_mask  out  NUM_REGS  registered pending-write bit per register.
- stall_count  out  CNT_W  saturating count of stall cycles since reset.
- err_spurious_wb  out  1  sticky: a writeback hit a non-pending, non-zero register.

Behaviour:
- Reset (rst_n low, async):
  - busy_mask = 0, stall_count = 0, err_spurious_wb = 0, state = RUN.
  - issue = 0 and stall = 0 while reset is asserted.
- Effective pending vector: eff = busy_mask with bit wb_reg cleared when wb_valid. The register file writes through, so same-cycle writeback resolves a hazard.
- hazard = (dec_uses_rs & eff[dec_rs] & dec_rs!=0) | (dec_uses_rt & eff[dec_rt] & dec_rt!=0) | (dec_writes & eff[dec_dest] & dec_dest!=0). The last term is WAW.
- FSM states: RUN, STALL, DRAIN. issue and stall are combinational from the state and the current inputs.
  - RUN:
    - dec_valid & !hazard -> issue=1, stay RUN.
    - dec_valid & hazard -> stall=1, next STALL.
    - !dec_valid -> issue=0, stall=0.
  - STALL:
    - stall=1 while hazard.
    - When hazard==0 -> issue=1, stall=0, next RUN. No bubble on release.
    - dec_valid dropping in STALL -> next RUN, no issue.
  - DRAIN:
    - issue=0; stall=dec_valid.
    - Stay until eff==0, then next RUN. The instruction may issue from RUN on the following cycle.
  - flush=1 in any state:
    - next DRAIN.
    - issue forced 0 that cycle; the decoded instruction is discarded, not held.
    - If eff==0 in the flush cycle, DRAIN still lasts exactly one cycle.
- busy_mask update each cycle:
  - Clear bit wb_reg if wb_valid.
  - Then set bit dec_dest if issue & dec_writes & dec_dest!=0.
  - Set wins over clear on the same index (new writer supersedes).
  - Bit 0 is always 0.
- Spurious writeback: wb_valid & wb_reg!=0 & !busy_mask[wb_reg] sets err_spurious_wb. The flag clears only on reset. Writebacks to register 0 are ignored.
- stall_count increments on every cycle with stall=1 and saturates at all-ones (no wrap).
- Writebacks continue to be accepted in every state, including DRAIN.
- Reset mid-stall or mid-drain: all state and tracking are discarded immediately (async).

Test Plan:
- After reset, issue add $3 (dec_writes, dest=3), then dec_uses_rs rs=3 next cycle -> cycle 1: issue=1, busy_mask=0x8; cycle 2: stall=1, state STALL, stall_count increments each stalled cycle.
- While stalled on $3, pulse wb_valid wb_reg=3 -> same cycle issue=1, stall=0; next cycle busy_mask=0 (or 0x8 again if the issued instruction also writes $3).
- dec_rs=0 and dest=0 with any busy_mask -> never stalls; busy_mask bit 0 stays 0.
- Pending $5 and $7, assert flush -> issue=0, DRAIN; wb $5 then wb $7 -> RUN the cycle after busy_mask reaches 0; dec_valid held throughout shows stall=1 during DRAIN.
- Same cycle: issue writes $4 and wb_reg=4 -> busy_mask[4]=1 afterward, err_spurious_wb stays 0 if $4 was pending.
- wb_valid wb_reg=9 with busy_mask=0 -> err_spurious_wb=1 and remains 1.
- Force 70000 stall cycles -> stall_count=0xFFFF, no wrap.
- Assert rst_n=0 mid-DRAIN -> all outputs return to 0 at once.
